// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM front end.
// Holds the arbiter/controller state encoding and a constant clog2 helper
// usable in parameter defaults.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_REFRESH = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: combinational winner picker.
// Rotates req down by ptr (round-robin) or by 0 (fixed priority), finds the
// lowest set bit, then rotates the index back.
//   req     in  NUM_CH  request vector
//   ptr     in  ID_W    round-robin start index (< NUM_CH)
//   rr_mode in  1       1 = round-robin, 0 = lowest index wins
//   valid   out 1       any request present
//   onehot  out NUM_CH  winner, one-hot (zero when !valid)
//   idx     out ID_W    winner index
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  input  logic              rr_mode,
  output logic              valid,
  output logic [NUM_CH-1:0] onehot,
  output logic [ID_W-1:0]   idx
);

  localparam logic [ID_W:0] NCH = (ID_W+1)'(NUM_CH);

  logic [ID_W-1:0]   sh;
  logic [NUM_CH-1:0] rot;
  logic [ID_W-1:0]   enc;
  logic [ID_W:0]     sum;

  assign sh    = rr_mode ? ptr : '0;
  assign valid = |req;

  // rot[i] = req[(i + sh) mod NUM_CH]
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int j;
      j = i + int'(sh);
      if (j >= NUM_CH) j = j - NUM_CH;
      rot[i] = req[j];
    end
  end

  // Lowest set bit of the rotated vector.
  always_comb begin
    enc = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (rot[i]) enc = ID_W'(i);
  end

  assign sum    = {1'b0, enc} + {1'b0, sh};
  assign idx    = (sum >= NCH) ? ID_W'(sum - NCH) : sum[ID_W-1:0];
  assign onehot = valid ? (NUM_CH'(1) << idx) : '0;

endmodule

// File: rtl/sdram_arbiter_rr.sv
// sdram_arbiter_rr: N-channel arbiter in front of the SDRAM controller.
// Refresh always wins from IDLE; requesters are served round-robin or by
// fixed priority; a hold limit preempts long owners when others wait; a
// GAP + IDLE pair separates every two ownerships so the row can be closed.
//   clk          in  1       clock (rising edge)
//   rst          in  1       async reset, active low
//   req          in  NUM_CH  per-channel level request
//   ack          out NUM_CH  per-channel grant, registered, one-hot or zero
//   grant_id     out ID_W    owner index, valid while |ack
//   refresh_req  in  1       refresh request, level
//   refresh_ack  out 1       refresh grant, registered
//   busy         out 1       high while in GRANT or REFRESH
module sdram_arbiter_rr
  import sdram_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 64,
  parameter int ID_W     = clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] ack,
  output logic [ID_W-1:0]   grant_id,
  input  logic              refresh_req,
  output logic              refresh_ack,
  output logic              busy
);

  localparam int HC_W = (MAX_HOLD > 0) ? clog2(MAX_HOLD+1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD-1 : 0);

  state_e            state_q;
  logic [NUM_CH-1:0] ack_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              refresh_ack_q;
  logic              busy_q;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HC_W-1:0]   hold_q;

  logic              pick_valid;
  logic [NUM_CH-1:0] pick_oh;
  logic [ID_W-1:0]   pick_idx;
  logic              others_pend;
  logic              preempt;

  rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .rr_mode (RR_MODE != 0),
    .valid   (pick_valid),
    .onehot  (pick_oh),
    .idx     (pick_idx)
  );

  // Winner moves to the back of the round-robin order.
  assign ptr_d = (pick_idx == ID_W'(NUM_CH-1)) ? '0 : pick_idx + 1'b1;

  // ack_q masks the owner, so this is "anyone else, or refresh".
  assign others_pend = (|(req & ~ack_q)) | refresh_req;
  assign preempt     = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) && others_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      ack_q         <= '0;
      grant_id_q    <= '0;
      refresh_ack_q <= 1'b0;
      busy_q        <= 1'b0;
      ptr_q         <= '0;
      hold_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (refresh_req) begin
            state_q       <= ST_REFRESH;
            refresh_ack_q <= 1'b1;
            busy_q        <= 1'b1;
          end else if (pick_valid) begin
            state_q    <= ST_GRANT;
            ack_q      <= pick_oh;
            grant_id_q <= pick_idx;
            busy_q     <= 1'b1;
            if (RR_MODE != 0) ptr_q <= ptr_d;
          end
        end
        ST_GRANT: begin
          if (hold_q != HOLD_LAST) hold_q <= hold_q + 1'b1;
          if (!req[grant_id_q] || preempt) begin
            state_q <= ST_GAP;
            ack_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_REFRESH: begin
          if (!refresh_req) begin
            state_q       <= ST_GAP;
            refresh_ack_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          hold_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign grant_id    = grant_id_q;
  assign refresh_ack = refresh_ack_q;
  assign busy        = busy_q;

endmodule

// File: doc/sdram_arbiter_rr.md
# sdram_arbiter_rr

Parametrised N-channel arbiter in front of the SDRAM controller; next generation of the two-port `sdram_arbiter`. It grants exactly one requester at a time, in round-robin or fixed-priority order. A refresh channel always wins. A hold limit preempts long owners when others are waiting. One idle cycle is always inserted between owners so the controller can close the open row.

## Interface
Parameters:
- `NUM_CH`, default 4: requester count, 2..16.
- `RR_MODE`, default 1: 1 selects round-robin, 0 selects fixed priority (lowest index wins).
- `MAX_HOLD`, default 64: maximum consecutive grant cycles while others wait. 0 disables preemption.
- `ID_W`, default `$clog2(NUM_CH)`: width of `grant_id`. Derived; do not override.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NUM_CH: per-channel request, level. Held high for the whole transaction.
- `ack` out NUM_CH: per-channel grant, registered, one-hot or zero.
- `grant_id` out ID_W: index of the granted channel. Valid only while `|ack`.
- `refresh_req` in 1: refresh request from the refresh timer, level.
- `refresh_ack` out 1: refresh grant, registered. Mutually exclusive with `ack`.
- `busy` out 1: high in GRANT or REFRESH state.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one `ack` bit high.
  - REFRESH: `refresh_ack` high.
  - GAP: one cycle, all grants low.
- IDLE transitions:
  - If `refresh_req` is high, go to REFRESH. This takes precedence over any `req`.
  - Else if `req` is non-zero, pick a winner and go to GRANT.
  - Else stay in IDLE.
- Winner selection:
  - `RR_MODE=1`: search from index `ptr`, wrapping to 0 after `NUM_CH-1`. On each grant to channel i, `ptr` becomes `(i+1) mod NUM_CH`.
  - `RR_MODE=0`: lowest set index wins. `ptr` is unused.
- GRANT:
  - The hold counter increments every cycle in GRANT.
  - Go to GAP when `req[owner]` drops.
  - Also go to GAP when `MAX_HOLD>0`, the counter has reached `MAX_HOLD-1`, and another `req` bit or `refresh_req` is high. That is preemption.
  - If no other request is pending, the owner keeps the grant indefinitely. The counter saturates at `MAX_HOLD-1`.
- REFRESH: go to GAP when `refresh_req` drops. Refresh is never preempted.
- GAP: always go to IDLE. The hold counter is cleared here.
- Preempted owner: must keep `req` high. It re-competes normally, and under round-robin it is now last in order.
- Request withdrawn while waiting (not granted): no effect. It is simply not selected.
- Request withdrawn on the same edge as preemption: treated as a normal release. Behaviour is identical.
- Reset values:
  - `ack`=0, `refresh_ack`=0, `grant_id`=0, `busy`=0.
  - State=IDLE, `ptr`=0, hold counter=0.
- Reset asserted mid-grant: all outputs drop immediately and asynchronously. The requester must re-request after reset is released.

## Timing
- Grant latency: `req` is sampled high in IDLE at edge N, so `ack` is high after edge N. `ack` is visible one cycle after the requester raises `req`.
- Release: `req[owner]` is sampled low at edge N, so `ack` is low after N. That cycle is GAP and IDLE follows. The next `ack` is visible after edge N+2 at earliest.
- Back-to-back minimum: any two ownerships are separated by exactly 1 all-low cycle (GAP) and 1 IDLE evaluation cycle.
- Preemption: `ack` is high for exactly `MAX_HOLD` cycles, then drops.
- `grant_id` and `busy` change on the same edge as `ack` / `refresh_ack`. Outputs are registered; there is no combinational path from `req` to `ack`.
- Worst-case wait with all channels requesting and no refresh, `RR_MODE=1`: (NUM_CH-1)·(MAX_HOLD+2) cycles.

## Structure
- Shared package `sdram_pkg`: state encodings `ST_IDLE`, `ST_GRANT`, `ST_REFRESH`, `ST_GAP`, and the clog2 helper. The SDRAM controller also uses these.
- Sub-module `rr_pick`: combinational, parametrised by `NUM_CH`.
  - Inputs: `req`, `ptr`, `rr_mode`.
  - Outputs: `valid`, one-hot `onehot`, index `idx`.
  - Implementation: rotate `req` by `ptr`, priority-encode, rotate back.
- Top level: FSM, hold counter (width `$clog2(MAX_HOLD+1)`), `ptr` register, and output registers.

## Test plan
- Single request: `NUM_CH=4`, `req=0001` held for 10 cycles. Expect `ack=0001` one cycle later for 10 cycles, `grant_id=0`, then 1 GAP cycle.
- Round-robin fairness: `req=1111` held, `MAX_HOLD=4`.
  - Grants go 0,1,2,3,0 in that order.
  - Each grant is exactly 4 cycles, with 2 non-granted cycles between grants.
- Fixed priority: `RR_MODE=0`, `req=0110` held, `MAX_HOLD=4`. Expect channel 1 to win every time and channel 2 never to be granted.
- Refresh precedence: `refresh_req` and `req=0011` rise together in IDLE.
  - `refresh_ack` comes first.
  - After `refresh_req` drops, `ack=0001` follows 2 cycles later.
  - `refresh_req` raised mid-grant preempts only at `MAX_HOLD`.
- No preemption when alone: `req=0100` held for 200 cycles with `MAX_HOLD=64`. `ack` stays continuously high.
- Async reset: assert `rst`=0 mid-grant, away from a clock edge. `ack` drops within the same cycle. After release, `ptr`=0, and `req=1111` grants channel 0 first.
